// File: rtl/rv32ima_pkg.sv
// Shared types and helpers for the arbitrated RAM: channel status, access-width
// codes, the idle load fill value and the byte-lane helpers.
package rv32ima_pkg;

  typedef enum logic [1:0] {
    RAM_FREE  = 2'b00,
    RAM_ADDR  = 2'b01,
    RAM_DATA  = 2'b10,
    RAM_ERROR = 2'b11
  } ram_state_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WAIT,
    ARB_DONE
  } arb_state_t;

  localparam logic [1:0]  RAM_W_BYTE = 2'b00;
  localparam logic [1:0]  RAM_W_HALF = 2'b01;
  localparam logic [1:0]  RAM_W_WORD = 2'b10;
  localparam logic [1:0]  RAM_W_ILL  = 2'b11;
  localparam logic [31:0] RAM_FILL   = 32'hdeadbeef;

  // Byte offset forced to the natural alignment of the access size.
  function automatic logic [1:0] ram_align_off(input logic [1:0] width, input logic [1:0] off);
    case (width)
      RAM_W_HALF: return {off[1], 1'b0};
      RAM_W_WORD: return 2'b00;
      default:    return off;
    endcase
  endfunction

  function automatic logic ram_misaligned(input logic [1:0] width, input logic [1:0] off);
    return ((width == RAM_W_HALF) && off[0]) || ((width == RAM_W_WORD) && (off != 2'b00));
  endfunction

  function automatic logic [3:0] ram_be(input logic [1:0] width, input logic [1:0] off);
    case (width)
      RAM_W_BYTE: return 4'b0001 << off;
      RAM_W_HALF: return 4'b0011 << off;
      default:    return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] ram_lane_mask(input logic [1:0] width);
    case (width)
      RAM_W_BYTE: return 32'h0000_00ff;
      RAM_W_HALF: return 32'h0000_ffff;
      default:    return 32'hffff_ffff;
    endcase
  endfunction

endpackage

// File: rtl/ram_bank.sv
// Single-port synchronous RAM, DEPTH x 32, byte-enabled writes, one-cycle read.
module ram_bank #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                                   i_clk,
  input  logic                                   i_en,
  input  logic                                   i_we,
  input  logic [3:0]                             i_be,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] i_addr,
  input  logic [31:0]                            i_wdata,
  output logic [31:0]                            o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_arb.sv
// Round-robin multi-channel front end for ram_bank with byte/half/word access.
// Define RAM_ALIGN_CHECK_EN to reject misaligned accesses instead of aligning them.
module ram_arb
  import rv32ima_pkg::*;
#(
  parameter int unsigned NCH   = 2,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned LAT   = 2
) (
  input  logic              ram_clk,
  input  logic              rst,
  input  logic [NCH-1:0]    ram_ren,
  input  logic [NCH-1:0]    ram_wen,
  input  logic [NCH*32-1:0] ram_addr,
  input  logic [NCH*2-1:0]  ram_width,
  input  logic [NCH*32-1:0] ram_store,
  output logic [NCH*2-1:0]  ram_state,
  output logic [NCH*32-1:0] ram_load
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;

  arb_state_t    r_state;
  logic [3:0]    r_cnt;
  logic [PW-1:0] r_gch;
  logic [PW-1:0] r_ptr;
  logic [AW-1:0] r_idx;
  logic [1:0]    r_off;
  logic [1:0]    r_width;
  logic [31:0]   r_store;
  logic          r_we;

  logic [NCH-1:0] w_req;
  logic [NCH-1:0] w_bad;
  logic [NCH-1:0] w_vld;
  logic [NCH-1:0] w_rot;
  logic           w_gnt;
  logic [PW-1:0]  w_gidx;
  logic [31:0]    w_addr_g;
  logic [1:0]     w_width_g;
  logic [31:0]    w_store_g;
  logic           w_wen_g;
  logic           w_mem_en;
  logic [31:0]    w_rdata;
  logic [31:0]    w_ldata;
  logic           w_unused_addr;

  always_comb begin
    w_req = '0;
    w_bad = '0;
    w_vld = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      w_req[i] = ram_ren[i] | ram_wen[i];
      w_bad[i] = w_req[i] & ((ram_ren[i] & ram_wen[i]) | (ram_width[2*i +: 2] == RAM_W_ILL));
`ifdef RAM_ALIGN_CHECK_EN
      if (w_req[i] && ram_misaligned(ram_width[2*i +: 2], ram_addr[32*i +: 2])) w_bad[i] = 1'b1;
`endif
      w_vld[i] = w_req[i] & ~w_bad[i];
    end
  end

  // Rotate the valid vector so bit 0 is the channel after the last grant.
  assign w_rot = NCH'({w_vld, w_vld} >> r_ptr);

  always_comb begin
    int unsigned sum;
    sum    = 0;
    w_gnt  = 1'b0;
    w_gidx = '0;
    for (int unsigned j = 0; j < NCH; j++) begin
      if (!w_gnt && w_rot[j]) begin
        sum = 32'(r_ptr) + j;
        if (sum >= NCH) sum = sum - NCH;
        w_gnt  = 1'b1;
        w_gidx = PW'(sum);
      end
    end
  end

  always_comb begin
    w_addr_g  = '0;
    w_width_g = '0;
    w_store_g = '0;
    w_wen_g   = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (w_gidx == PW'(i)) begin
        w_addr_g  = ram_addr[32*i +: 32];
        w_width_g = ram_width[2*i +: 2];
        w_store_g = ram_store[32*i +: 32];
        w_wen_g   = ram_wen[i];
      end
    end
  end

  assign w_unused_addr = ^w_addr_g[31:AW+2];

  always_ff @(posedge ram_clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB_IDLE;
      r_cnt   <= '0;
      r_gch   <= '0;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_off   <= '0;
      r_width <= '0;
      r_store <= '0;
      r_we    <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_gnt) begin
            r_state <= ARB_WAIT;
            r_cnt   <= 4'(LAT);
            r_gch   <= w_gidx;
            r_ptr   <= (w_gidx == PW'(NCH - 1)) ? '0 : w_gidx + 1'b1;
            r_idx   <= w_addr_g[AW+1:2];
            r_off   <= ram_align_off(w_width_g, w_addr_g[1:0]);
            r_width <= w_width_g;
            r_store <= w_store_g;
            r_we    <= w_wen_g;
          end
        end
        ARB_WAIT: begin
          if (r_cnt == '0) r_state <= ARB_DONE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        ARB_DONE: r_state <= ARB_IDLE;
        default:  r_state <= ARB_IDLE;
      endcase
    end
  end

  // The last WAIT cycle is the memory cycle; read data lands in DONE.
  assign w_mem_en = (r_state == ARB_WAIT) && (r_cnt == '0);

  ram_bank #(
    .DEPTH(DEPTH)
  ) u_bank (
    .i_clk   (ram_clk),
    .i_en    (w_mem_en),
    .i_we    (r_we),
    .i_be    (ram_be(r_width, r_off)),
    .i_addr  (r_idx),
    .i_wdata (r_store << {r_off, 3'b000}),
    .o_rdata (w_rdata)
  );

  assign w_ldata = (w_rdata >> {r_off, 3'b000}) & ram_lane_mask(r_width);

  // Status is combinational so a requester sees RAM_ADDR in its request cycle.
  always_comb begin
    ram_state = '0;
    ram_load  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (rst)
        ram_state[2*i +: 2] = RAM_FREE;
      else if ((r_state != ARB_IDLE) && (r_gch == PW'(i)))
        ram_state[2*i +: 2] = (r_state == ARB_DONE) ? RAM_DATA : RAM_ADDR;
      else if (w_bad[i])
        ram_state[2*i +: 2] = RAM_ERROR;
      else if (w_req[i])
        ram_state[2*i +: 2] = RAM_ADDR;
      else
        ram_state[2*i +: 2] = RAM_FREE;

      if (!rst && (r_state == ARB_DONE) && (r_gch == PW'(i)) && !r_we)
        ram_load[32*i +: 32] = w_ldata;
      else
        ram_load[32*i +: 32] = RAM_FILL;
    end
  end

endmodule

// File: doc/ram_arb.md
RAM_ARB -- requirements
Module: ram_arb

Interface
REQ-001 Parameter NCH, default 2: number of requester channels, 1..8.
REQ-002 Parameter DEPTH, default 1024: memory depth in 32-bit words, power of two.
REQ-003 Parameter LAT, default 2: extra wait cycles between grant and data, 0..15.
REQ-004 ram_clk  in  1  single block clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 ram_ren  in  NCH  per-channel read request.
REQ-007 ram_wen  in  NCH  per-channel write request.
REQ-008 ram_addr  in  NCHx32  per-channel byte address.
REQ-009 ram_width  in  NCHx2  per-channel access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-010 ram_store  in  NCHx32  per-channel store data, right-justified.
REQ-011 ram_state  out  NCHx2  per-channel ram_state_t: RAM_FREE, RAM_ADDR, RAM_DATA, RAM_ERROR.
REQ-012 ram_load  out  NCHx32  per-channel load data, right-justified and zero-extended.

Function
REQ-013 The controller SHALL be an FSM with states IDLE, WAIT and DONE.
REQ-014 In IDLE, if any channel requests, it SHALL grant one channel round-robin, starting from the channel after the last granted one (channel 0 after reset), latch its addr/width/store/op, and go to WAIT.
REQ-015 The latch SHALL be taken at grant; the requester SHALL hold ren/wen until it sees RAM_DATA; an earlier drop SHALL NOT abort the access.
REQ-016 WAIT SHALL last LAT cycles plus one memory read cycle; DONE SHALL last exactly one cycle, then go to IDLE; the next grant SHALL occur in the cycle after DONE, so the total is LAT+3 cycles per access from the request cycle.
REQ-017 The granted channel SHALL see RAM_ADDR from its request cycle through WAIT, then RAM_DATA in DONE; ram_load SHALL be valid only in DONE for reads.
REQ-018 Non-granted requesting channels SHALL see RAM_ADDR; idle channels SHALL see RAM_FREE.
REQ-019 ram_load SHALL be 32'hdeadbeef when the channel is not in DONE with a read.
REQ-020 Byte enables SHALL be: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111. Store data SHALL be shifted into the addressed lanes; load data SHALL be shifted down and zero-extended.
REQ-021 The word index SHALL be addr[1:0] dropped, modulo DEPTH, so addresses wrap.
REQ-022 ren and wen together, or width 11, SHALL give RAM_ERROR to that channel for one cycle with no grant and no memory access; arbitration SHALL then skip that channel for that cycle.
REQ-023 A write SHALL update memory at the end of the WAIT memory cycle; a read granted afterwards SHALL return the new data.

Reset
REQ-024 On rst: FSM to IDLE, round-robin pointer to 0, latches and counter cleared, all ram_state RAM_FREE, all ram_load 32'hdeadbeef.
REQ-025 Reset mid-access SHALL abandon that access; a pending write SHALL either complete fully or not at all. Memory contents are not reset.

Configuration
REQ-026 Macro RAM_ALIGN_CHECK_EN defined: half with addr[0]=1, or word with addr[1:0]!=0, SHALL be treated per REQ-022 (RAM_ERROR, no access).
REQ-027 Without RAM_ALIGN_CHECK_EN, misaligned low address bits SHALL be forced to natural alignment (half clears addr[0], word clears addr[1:0]) and the access SHALL proceed.

Structure
REQ-028 ram_state_t, width encodings and the 32'hdeadbeef fill constant SHALL live in rv32ima_pkg.
REQ-029 Storage SHALL be the sub-module ram_bank: a single-port synchronous RAM of DEPTH x 32 with 4-bit byte enable and one-cycle read.

Verification
REQ-030 LAT=2: ch0 writes word 0x12345678 to 0x10, then reads 0x10 -> RAM_DATA 5 cycles after request; load 0x12345678.
REQ-031 ch0 and ch1 read at once, repeatedly -> grants alternate 0,1,0,1; the waiting channel sees RAM_ADDR.
REQ-032 Byte write 0xAB to 0x13 over word 0 at 0x10, then half read at 0x12 -> load 0x0000AB00.
REQ-033 ren=wen=1 on ch1, or width=11 -> RAM_ERROR for one cycle; memory unchanged.
REQ-034 With RAM_ALIGN_CHECK_EN, word read at 0x11 -> RAM_ERROR; without it -> data from 0x10.
REQ-035 rst in WAIT -> all outputs RAM_FREE/0xdeadbeef at once; the next request is granted to ch0.
